parity_rx: RTL and testbench

PARITY_RX -- requirements
Module: parity_rx

---
 rtl/parity_rx.sv | 124 ++++++++++++
 tb/tb_parity_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_rx.sv
// Serial frame receiver: start, 8 data bits LSB first, parity, stop.
// Optional error counter output enabled by defining PARITY_RX_ERR_COUNT_EN.
module parity_rx (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       enable,
  input  logic       sdata,
  input  logic       odd_sel,
  output logic [7:0] data,
  output logic       valid,
  output logic       par_err,
  output logic       frame_err,
  output logic       busy
`ifdef PARITY_RX_ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [7:0] sr_q;
  logic       odd_q;
  logic       perr_q;
  logic       start;
  logic       shift;
  logic       par_smp;
  logic       stop_smp;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-edge strobes; nothing moves without enable
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift    = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (!sdata) begin
            state_d = DATA;
            start   = 1'b1;
          end
        end
        DATA: begin
          shift = 1'b1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_smp = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          stop_smp = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register, bit counter, captured mode and parity result
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= 3'd0;
      sr_q   <= 8'h00;
      odd_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= 3'd0;
        odd_q <= odd_sel;
      end
      if (shift) begin
        sr_q  <= {sdata, sr_q[7:1]};
        cnt_q <= cnt_q + 3'd1;
      end
      if (par_smp) perr_q <= (^sr_q) ^ sdata ^ odd_q;
    end
  end

  // Frame results, updated only on the stop-bit edge
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= stop_smp;
      if (stop_smp) begin
        data      <= sr_q;
        par_err   <= perr_q;
        frame_err <= ~sdata;
      end
    end
  end

  assign busy = (state_q != IDLE);

`ifdef PARITY_RX_ERR_COUNT_EN
  // Saturating count of frames delivered with any error flag
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) err_cnt <= 8'h00;
    else if (stop_smp && (perr_q || !sdata) && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: scoreboard of expected frames popped on valid.
// Define PARITY_RX_ERR_COUNT_EN to also exercise the error counter.
module tb_parity_rx;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       enable;
  logic       sdata;
  logic       odd_sel;
  logic [7:0] data;
  logic       valid;
  logic       par_err;
  logic       frame_err;
  logic       busy;
`ifdef PARITY_RX_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  logic prev_valid = 1'b0;
  logic [9:0] exp_q[$];

  parity_rx dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .enable    (enable),
    .sdata     (sdata),
    .odd_sel   (odd_sel),
    .data      (data),
    .valid     (valid),
    .par_err   (par_err),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef PARITY_RX_ERR_COUNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: pop expected frame on each valid pulse
  always @(negedge clk) begin
    logic [9:0] e;
    if (valid) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got data=%h pe=%b fe=%b",
                 data, par_err, frame_err);
      end else begin
        e = exp_q.pop_front();
        if ({data, par_err, frame_err} !== e) begin
          failures++;
          $display("FAIL frame got data=%h pe=%b fe=%b exp data=%h pe=%b fe=%b",
                   data, par_err, frame_err, e[9:2], e[1], e[0]);
        end
      end
      if (prev_valid) begin
        checks++;
        failures++;
        $display("FAIL valid_width got two-cycle pulse exp one cycle");
      end
    end
    prev_valid = valid;
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    enable = 1'b1;
    sdata  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      sdata  = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb,
                            input logic sb, input int gap_at,
                            input int gap_len);
    logic [10:0] bits;
    int ones;
    logic exp_pe;
    bits   = {sb, pb, d, 1'b0};
    ones   = $countones(d) + int'(pb);
    exp_pe = odd_sel ? (ones % 2 == 0) : (ones % 2 == 1);
    exp_q.push_back({d, exp_pe, ~sb});
    for (int i = 0; i < 11; i++) begin
      drive_bit(bits[i]);
      if (i == gap_at) begin
        repeat (gap_len) begin
          @(negedge clk);
          enable  = 1'b0;
          sdata   = 1'($urandom_range(0, 1));
          odd_sel = ~odd_sel;
        end
      end
      if (i == 9) begin
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL pre_stop got valid=%b busy=%b exp valid=0 busy=1",
                   valid, busy);
        end
      end
    end
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL latency got valid=%b exp 1 after 11th edge", valid);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; enable = 1'b0; sdata = 1'b1; odd_sel = 1'b0;
    #13;
    checks++;
    if ({data, valid, par_err, frame_err, busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset got data=%h v=%b pe=%b fe=%b busy=%b exp zeros",
               data, valid, par_err, frame_err, busy);
    end
    @(negedge clk);
    clr_n = 1'b1;
    idle(3);
  endtask

  task automatic test_basic();
    int nv;
    nv = n_valid;
    odd_sel = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, -1, 0);
    idle(6);
    checks++;
    if (data !== 8'hA5 || par_err !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL hold got data=%h pe=%b fe=%b exp a5 0 0",
               data, par_err, frame_err);
    end
    checks++;
    if (n_valid !== nv + 1) begin
      failures++;
      $display("FAIL basic_count got %0d exp %0d", n_valid - nv, 1);
    end
  endtask

  task automatic test_parity();
    odd_sel = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b1, -1, 0);
    idle(2);
    checks++;
    if (par_err !== 1'b1) begin
      failures++;
      $display("FAIL even_bad got pe=%b exp 1", par_err);
    end
    odd_sel = 1'b1;
    send_frame(8'h01, 1'b0, 1'b1, -1, 0);
    idle(2);
    checks++;
    if (par_err !== 1'b0 || data !== 8'h01) begin
      failures++;
      $display("FAIL odd_ok got pe=%b data=%h exp 0 01", par_err, data);
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = n_valid;
    odd_sel = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, -1, 0);
    send_frame(8'h3C, 1'b0, 1'b1, -1, 0);
    idle(3);
    checks++;
    if (n_valid !== nv + 2 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b got pulses=%0d fe=%b exp 2 0", n_valid - nv, frame_err);
    end
  endtask

  task automatic test_stall();
    int nv;
    nv = n_valid;
    odd_sel = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 4, 5);
    idle(4);
    checks++;
    if (n_valid !== nv + 1 || data !== 8'h5A || par_err !== 1'b0) begin
      failures++;
      $display("FAIL stall got pulses=%0d data=%h pe=%b exp 1 5a 0",
               n_valid - nv, data, par_err);
    end
  endtask

  task automatic test_abort();
    logic [10:0] bits;
    int nv;
    nv = n_valid;
    odd_sel = 1'b0;
    bits = {1'b1, 1'b0, 8'h77, 1'b0};
    for (int i = 0; i < 9; i++) drive_bit(bits[i]);
    @(negedge clk);
    enable = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({data, valid, par_err, frame_err, busy} !== 12'h000) begin
      failures++;
      $display("FAIL abort got data=%h v=%b pe=%b fe=%b busy=%b exp zeros",
               data, valid, par_err, frame_err, busy);
    end
    @(negedge clk);
    clr_n = 1'b1;
    idle(4);
    checks++;
    if (n_valid !== nv) begin
      failures++;
      $display("FAIL abort_valid got pulses=%0d exp 0", n_valid - nv);
    end
    send_frame(8'hFF, 1'b0, 1'b1, -1, 0);
    idle(3);
    checks++;
    if (data !== 8'hFF || par_err !== 1'b0 || n_valid !== nv + 1) begin
      failures++;
      $display("FAIL post_reset got data=%h pe=%b exp ff 0", data, par_err);
    end
  endtask

`ifdef PARITY_RX_ERR_COUNT_EN
  task automatic test_err_count();
    int exp_cnt;
    exp_cnt = 0;
    odd_sel = 1'b0;
    for (int i = 0; i < 260; i++) begin
      send_frame(8'h01, 1'b0, 1'b1, -1, 0);
      idle(1);
      if (exp_cnt < 255) exp_cnt++;
      if (i == 9 || i == 259) begin
        checks++;
        if (err_cnt !== 8'(exp_cnt)) begin
          failures++;
          $display("FAIL err_cnt got %0d exp %0d", err_cnt, exp_cnt);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_stall();
    test_abort();
`ifdef PARITY_RX_ERR_COUNT_EN
    test_err_count();
`endif
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_frames got %0d pending exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
